// File: rtl/rat_multi_ckpt_if.sv
// Rename / commit-free / checkpoint bundle between decode, the rename table and dispatch.
// The master side issues requests; the slave side (the rename table) answers.
interface rat_multi_ckpt_if #(
  parameter int unsigned NUM_ARCH_REGS = 8,
  parameter int unsigned NUM_PHYS_REGS = 16,
  parameter int unsigned RENAME_WIDTH  = 2,
  parameter int unsigned FREE_WIDTH    = 2
);
  localparam int unsigned AW = $clog2(NUM_ARCH_REGS);
  localparam int unsigned PW = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CW = $clog2(NUM_PHYS_REGS + 1);

  logic [RENAME_WIDTH-1:0]    ren_valid;
  logic [RENAME_WIDTH*AW-1:0] ren_dest;
  logic [RENAME_WIDTH*AW-1:0] ren_src1;
  logic [RENAME_WIDTH*AW-1:0] ren_src2;
  logic                       ren_ready;
  logic [RENAME_WIDTH*PW-1:0] ren_pdest;
  logic [RENAME_WIDTH*PW-1:0] ren_old_pdest;
  logic [RENAME_WIDTH-1:0]    ren_old_valid;
  logic [RENAME_WIDTH*PW-1:0] ren_psrc1;
  logic [RENAME_WIDTH*PW-1:0] ren_psrc2;
  logic [RENAME_WIDTH-1:0]    ren_src1_found;
  logic [RENAME_WIDTH-1:0]    ren_src2_found;
  logic [FREE_WIDTH-1:0]      free_valid;
  logic [FREE_WIDTH*PW-1:0]   free_preg;
  logic                       ckpt_save;
  logic                       ckpt_restore;
  logic                       ckpt_valid;
  logic [CW-1:0]              free_count;

  modport master (
    output ren_valid, ren_dest, ren_src1, ren_src2, free_valid, free_preg,
           ckpt_save, ckpt_restore,
    input  ren_ready, ren_pdest, ren_old_pdest, ren_old_valid, ren_psrc1, ren_psrc2,
           ren_src1_found, ren_src2_found, ckpt_valid, free_count
  );

  modport slave (
    input  ren_valid, ren_dest, ren_src1, ren_src2, free_valid, free_preg,
           ckpt_save, ckpt_restore,
    output ren_ready, ren_pdest, ren_old_pdest, ren_old_valid, ren_psrc1, ren_psrc2,
           ren_src1_found, ren_src2_found, ckpt_valid, free_count
  );
endinterface

// File: rtl/rat_multi_ckpt.sv
// Superscalar register alias table with packed free-list allocation, commit reclaim
// and a single branch checkpoint that restores map and free list in one cycle.
module rat_multi_ckpt #(
  parameter int unsigned NUM_ARCH_REGS = 8,
  parameter int unsigned NUM_PHYS_REGS = 16,
  parameter int unsigned RENAME_WIDTH  = 2,
  parameter int unsigned FREE_WIDTH    = 2,
  parameter int unsigned INIT_MAP      = 1
) (
  input logic            i_clk,
  input logic            i_rst_n,
  rat_multi_ckpt_if.slave bus
);
  localparam int unsigned AW = $clog2(NUM_ARCH_REGS);
  localparam int unsigned PW = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CW = $clog2(NUM_PHYS_REGS + 1);

  typedef logic [NUM_ARCH_REGS-1:0][PW-1:0] map_t;

  function automatic map_t f_rst_map();
    map_t m;
    for (int i = 0; i < NUM_ARCH_REGS; i++) m[i] = (INIT_MAP != 0) ? PW'(i) : '0;
    return m;
  endfunction

  localparam map_t                     RST_MAP   = f_rst_map();
  localparam logic [NUM_ARCH_REGS-1:0] RST_VLD   = (INIT_MAP != 0) ? '1 : '0;
  localparam logic [NUM_PHYS_REGS-1:0] RST_FREE  =
      (INIT_MAP != 0) ? ({NUM_PHYS_REGS{1'b1}} << NUM_ARCH_REGS) : '1;
  localparam logic [CW-1:0]            RST_COUNT =
      CW'((INIT_MAP != 0) ? (NUM_PHYS_REGS - NUM_ARCH_REGS) : NUM_PHYS_REGS);

  map_t                     r_map, w_map_d, r_snap_map;
  logic [NUM_ARCH_REGS-1:0] r_map_vld, w_map_vld_d, r_snap_vld;
  logic [NUM_PHYS_REGS-1:0] r_free, w_free_d, r_snap_free, r_freed_since, w_freed_since_d;
  logic [CW-1:0]            r_count, w_count_d;
  logic                     r_ckpt_valid, w_ckpt_valid_d, w_snap_en, w_do_restore;

  logic [NUM_PHYS_REGS-1:0]   w_avail, w_alloc_mask, w_newfree;
  logic [CW-1:0]              w_nreq;
  logic                       w_got, w_ready, w_accept, w_double_free;
  logic [RENAME_WIDTH*PW-1:0] w_pdest, w_old_pdest, w_psrc1, w_psrc2;
  logic [RENAME_WIDTH-1:0]    w_old_valid, w_found1, w_found2;

  // Lane k takes the k-th lowest free reg; lookups see older lanes' new mappings.
  always_comb begin
    w_avail      = r_free;
    w_alloc_mask = '0;
    w_nreq       = '0;
    w_got        = 1'b0;
    w_pdest      = '0;
    w_old_pdest  = '0;
    w_old_valid  = '0;
    w_psrc1      = '0;
    w_psrc2      = '0;
    w_found1     = '0;
    w_found2     = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      w_got = 1'b0;
      if (bus.ren_valid[k]) begin
        w_nreq = w_nreq + CW'(1);
        for (int p = 0; p < NUM_PHYS_REGS; p++) begin
          if (!w_got && w_avail[p]) begin
            w_avail[p]            = 1'b0;
            w_alloc_mask[p]       = 1'b1;
            w_pdest[k*PW +: PW]   = PW'(p);
            w_got                 = 1'b1;
          end
        end
        w_old_pdest[k*PW +: PW] = r_map[bus.ren_dest[k*AW +: AW]];
        w_old_valid[k]          = r_map_vld[bus.ren_dest[k*AW +: AW]];
        w_psrc1[k*PW +: PW]     = r_map[bus.ren_src1[k*AW +: AW]];
        w_found1[k]             = r_map_vld[bus.ren_src1[k*AW +: AW]];
        w_psrc2[k*PW +: PW]     = r_map[bus.ren_src2[k*AW +: AW]];
        w_found2[k]             = r_map_vld[bus.ren_src2[k*AW +: AW]];
        for (int j = 0; j < RENAME_WIDTH; j++) begin
          if (j < k && bus.ren_valid[j]) begin
            if (bus.ren_dest[j*AW +: AW] == bus.ren_dest[k*AW +: AW]) begin
              w_old_pdest[k*PW +: PW] = w_pdest[j*PW +: PW];
              w_old_valid[k]          = 1'b1;
            end
            if (bus.ren_dest[j*AW +: AW] == bus.ren_src1[k*AW +: AW]) begin
              w_psrc1[k*PW +: PW] = w_pdest[j*PW +: PW];
              w_found1[k]         = 1'b1;
            end
            if (bus.ren_dest[j*AW +: AW] == bus.ren_src2[k*AW +: AW]) begin
              w_psrc2[k*PW +: PW] = w_pdest[j*PW +: PW];
              w_found2[k]         = 1'b1;
            end
          end
        end
      end
    end
  end

  assign w_ready      = !bus.ckpt_restore && (r_count >= w_nreq);
  assign w_accept     = w_ready && (|bus.ren_valid);
  assign w_do_restore = bus.ckpt_restore && r_ckpt_valid;

  always_comb begin
    w_newfree     = '0;
    w_double_free = 1'b0;
    for (int f = 0; f < FREE_WIDTH; f++) begin
      if (bus.free_valid[f]) begin
        w_newfree[bus.free_preg[f*PW +: PW]] = 1'b1;
        if (r_free[bus.free_preg[f*PW +: PW]]) w_double_free = 1'b1;
      end
    end
    w_map_d     = r_map;
    w_map_vld_d = r_map_vld;
    if (w_accept) begin
      // Ascending lane order lets the youngest lane win on a shared dest.
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        if (bus.ren_valid[k]) begin
          w_map_d[bus.ren_dest[k*AW +: AW]]     = w_pdest[k*PW +: PW];
          w_map_vld_d[bus.ren_dest[k*AW +: AW]] = 1'b1;
        end
      end
    end
    w_free_d         = (r_free & ~(w_accept ? w_alloc_mask : '0)) | w_newfree;
    w_freed_since_d  = r_freed_since | w_newfree;
    w_ckpt_valid_d   = r_ckpt_valid;
    w_snap_en        = 1'b0;
    if (w_do_restore) begin
      w_map_d         = r_snap_map;
      w_map_vld_d     = r_snap_vld;
      w_free_d        = r_snap_free | r_freed_since | w_newfree;
      w_freed_since_d = '0;
      w_ckpt_valid_d  = 1'b0;
    end else if (bus.ckpt_save) begin
      w_freed_since_d = '0;
      w_ckpt_valid_d  = 1'b1;
      w_snap_en       = 1'b1;
    end
    w_count_d = '0;
    for (int p = 0; p < NUM_PHYS_REGS; p++) w_count_d = w_count_d + CW'(w_free_d[p]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_map         <= RST_MAP;
      r_map_vld     <= RST_VLD;
      r_free        <= RST_FREE;
      r_count       <= RST_COUNT;
      r_freed_since <= '0;
      r_ckpt_valid  <= 1'b0;
      r_snap_map    <= RST_MAP;
      r_snap_vld    <= RST_VLD;
      r_snap_free   <= RST_FREE;
    end else begin
      r_map         <= w_map_d;
      r_map_vld     <= w_map_vld_d;
      r_free        <= w_free_d;
      r_count       <= w_count_d;
      r_freed_since <= w_freed_since_d;
      r_ckpt_valid  <= w_ckpt_valid_d;
      if (w_snap_en) begin
        r_snap_map  <= w_map_d;
        r_snap_vld  <= w_map_vld_d;
        r_snap_free <= w_free_d;
      end
    end
  end

  a_no_double_free: assert property (@(posedge i_clk) disable iff (!i_rst_n) !w_double_free);

  assign bus.ren_ready      = w_ready;
  assign bus.ren_pdest      = w_pdest;
  assign bus.ren_old_pdest  = w_old_pdest;
  assign bus.ren_old_valid  = w_old_valid;
  assign bus.ren_psrc1      = w_psrc1;
  assign bus.ren_psrc2      = w_psrc2;
  assign bus.ren_src1_found = w_found1;
  assign bus.ren_src2_found = w_found2;
  assign bus.ckpt_valid     = r_ckpt_valid;
  assign bus.free_count     = r_count;
endmodule

// File: tb/tb_rat_multi_ckpt.sv
// Scoreboard bench for rat_multi_ckpt: directed rename/free/checkpoint vectors push
// expected responses; a negedge monitor compares whenever a rename request is presented.
module tb_rat_multi_ckpt;
  localparam int unsigned AW = 3;
  localparam int unsigned PW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rat_multi_ckpt_if #(
    .NUM_ARCH_REGS(8), .NUM_PHYS_REGS(16), .RENAME_WIDTH(2), .FREE_WIDTH(2)
  ) bus ();

  rat_multi_ckpt #(
    .NUM_ARCH_REGS(8), .NUM_PHYS_REGS(16), .RENAME_WIDTH(2), .FREE_WIDTH(2), .INIT_MAP(1)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic            rdy;
    logic [4:0]      fc;
    logic            cv;
    logic [1:0][3:0] pd;
    logic [1:0][3:0] op;
    logic [1:0]      ov;
    logic [1:0][3:0] ps1;
    logic [1:0]      f1;
    logic [1:0][3:0] ps2;
    logic [1:0]      f2;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic ex(input logic rdy, input int fc, input logic cv, input int pd0, input int pd1,
                    input int op0, input int op1, input logic [1:0] ov,
                    input int s10, input int s11, input logic [1:0] f1,
                    input int s20, input int s21, input logic [1:0] f2);
    exp_t e;
    e.rdy = rdy;        e.fc = 5'(fc);       e.cv = cv;
    e.pd[0] = 4'(pd0);  e.pd[1] = 4'(pd1);
    e.op[0] = 4'(op0);  e.op[1] = 4'(op1);   e.ov = ov;
    e.ps1[0] = 4'(s10); e.ps1[1] = 4'(s11);  e.f1 = f1;
    e.ps2[0] = 4'(s20); e.ps2[1] = 4'(s21);  e.f2 = f2;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (|bus.ren_valid) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", q.size(), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ren_ready", bus.ren_ready, e.rdy);
        chk("free_count", bus.free_count, e.fc);
        chk("ckpt_valid", bus.ckpt_valid, e.cv);
        for (int k = 0; k < 2; k++) begin
          if (e.rdy) chk($sformatf("pdest%0d", k), bus.ren_pdest[k*PW +: PW], e.pd[k]);
          chk($sformatf("old_pdest%0d", k), bus.ren_old_pdest[k*PW +: PW], e.op[k]);
          chk($sformatf("old_valid%0d", k), bus.ren_old_valid[k], e.ov[k]);
          chk($sformatf("psrc1_%0d", k), bus.ren_psrc1[k*PW +: PW], e.ps1[k]);
          chk($sformatf("src1_found%0d", k), bus.ren_src1_found[k], e.f1[k]);
          chk($sformatf("psrc2_%0d", k), bus.ren_psrc2[k*PW +: PW], e.ps2[k]);
          chk($sformatf("src2_found%0d", k), bus.ren_src2_found[k], e.f2[k]);
        end
      end
    end
  end

  task automatic idle();
    bus.ren_valid    = '0;
    bus.ren_dest     = '0;
    bus.ren_src1     = '0;
    bus.ren_src2     = '0;
    bus.free_valid   = '0;
    bus.free_preg    = '0;
    bus.ckpt_save    = 1'b0;
    bus.ckpt_restore = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] v, input int d0, input int s10, input int s20,
                         input int d1, input int s11, input int s21);
    bus.ren_valid = v;
    bus.ren_dest  = {AW'(d1), AW'(d0)};
    bus.ren_src1  = {AW'(s11), AW'(s10)};
    bus.ren_src2  = {AW'(s21), AW'(s20)};
  endtask

  task automatic set_free(input logic [1:0] fv, input int p0, input int p1);
    bus.free_valid = fv;
    bus.free_preg  = {PW'(p1), PW'(p0)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset map, two-lane rename with lane1 reading lane0's dest.
    idle(); set_req(2'b11, 3, 1, 2, 5, 3, 0);
    ex(1, 8, 0, 8, 9, 3, 5, 2'b11, 1, 8, 2'b11, 2, 0, 2'b11); step();
    idle(); set_req(2'b01, 6, 3, 5, 0, 0, 0);
    ex(1, 6, 0, 10, 0, 6, 0, 2'b01, 8, 0, 2'b01, 9, 0, 2'b01); step();
    // Same dest in both lanes.
    idle(); set_req(2'b11, 2, 0, 1, 2, 2, 6);
    ex(1, 5, 0, 11, 12, 2, 11, 2'b11, 0, 11, 2'b11, 1, 10, 2'b11); step();
    idle(); set_req(2'b11, 7, 2, 4, 0, 7, 2);
    ex(1, 3, 0, 13, 14, 7, 0, 2'b11, 12, 13, 2'b11, 4, 12, 2'b11); step();
    // One free reg left: two lanes rejected, one lane accepted.
    idle(); set_req(2'b11, 1, 1, 3, 4, 3, 0);
    ex(0, 1, 0, 0, 0, 1, 4, 2'b11, 1, 8, 2'b11, 8, 14, 2'b11); step();
    idle(); set_req(2'b01, 1, 1, 3, 0, 0, 0);
    ex(1, 1, 0, 15, 0, 1, 0, 2'b01, 1, 0, 2'b01, 8, 0, 2'b01); step();
    // Free while empty: not allocatable until next cycle.
    idle(); set_req(2'b01, 5, 6, 7, 0, 0, 0); set_free(2'b01, 3, 0);
    ex(0, 0, 0, 0, 0, 9, 0, 2'b01, 10, 0, 2'b01, 13, 0, 2'b01); step();
    idle(); set_req(2'b01, 5, 6, 7, 0, 0, 0);
    ex(1, 1, 0, 3, 0, 9, 0, 2'b01, 10, 0, 2'b01, 13, 0, 2'b01); step();
    idle(); set_req(2'b01, 0, 5, 2, 0, 0, 0); set_free(2'b11, 9, 11);
    ex(0, 0, 0, 0, 0, 14, 0, 2'b01, 3, 0, 2'b01, 12, 0, 2'b01); step();
    // Checkpoint, rename + commit free, then restore.
    idle(); bus.ckpt_save = 1'b1; set_free(2'b01, 0, 0); step();
    idle(); set_req(2'b11, 1, 4, 1, 4, 1, 4); set_free(2'b01, 2, 0);
    ex(1, 3, 1, 0, 9, 15, 4, 2'b11, 4, 0, 2'b11, 15, 4, 2'b11); step();
    idle(); bus.ckpt_restore = 1'b1; set_req(2'b01, 6, 1, 4, 0, 0, 0); set_free(2'b01, 5, 0);
    ex(0, 2, 1, 0, 0, 10, 0, 2'b01, 0, 0, 2'b01, 9, 0, 2'b01); step();
    idle(); bus.ckpt_restore = 1'b1; set_req(2'b11, 1, 4, 1, 2, 4, 3);
    ex(0, 5, 0, 0, 0, 15, 12, 2'b11, 4, 4, 2'b11, 15, 8, 2'b11); step();
    idle(); set_req(2'b11, 1, 1, 4, 4, 1, 0);
    ex(1, 5, 0, 0, 2, 15, 4, 2'b11, 15, 0, 2'b11, 4, 14, 2'b11); step();
    // Duplicate free in one cycle counts once.
    idle(); set_free(2'b11, 6, 6); step();
    idle(); set_req(2'b11, 7, 7, 6, 6, 7, 6);
    ex(1, 4, 0, 5, 6, 13, 10, 2'b11, 13, 5, 2'b11, 10, 10, 2'b11); step();
    // Async reset between edges with a group presented.
    idle(); set_req(2'b11, 3, 3, 7, 4, 3, 1);
    #1 rst_n = 1'b0;
    ex(1, 8, 0, 8, 9, 3, 4, 2'b11, 3, 8, 2'b11, 7, 1, 2'b11);
    @(posedge clk);
    #1 idle(); rst_n = 1'b1;
    set_req(2'b01, 3, 3, 0, 0, 0, 0);
    ex(1, 8, 0, 8, 0, 3, 0, 2'b01, 3, 0, 2'b01, 0, 0, 2'b01); step();

    idle(); step();
    chk("scoreboard_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rat_multi_ckpt.md
Name: rat_multi_ckpt

Overview:
Superscalar register alias table with an integrated free list, commit-driven register reclaim and one branch checkpoint. It renames up to RENAME_WIDTH instructions per cycle, with intra-group dependency bypass, and returns the previous mapping of each destination to the ROB. It accepts physical registers freed at commit. A mispredict restores the saved map in one cycle. It sits between decode and dispatch, and is the next generation of the single-lane rename table.

Parameters:
NUM_ARCH_REGS, 8, architectural register count (power of two)
NUM_PHYS_REGS, 16, physical register count; must be >= NUM_ARCH_REGS + RENAME_WIDTH
RENAME_WIDTH, 2, rename lanes per cycle
FREE_WIDTH, 2, commit free ports per cycle
INIT_MAP, 1, 1 = arch i maps to phys i at reset and p[NUM_ARCH_REGS..] are free; 0 = all unmapped and all free
(derived) AW = $clog2(NUM_ARCH_REGS), PW = $clog2(NUM_PHYS_REGS), CW = $clog2(NUM_PHYS_REGS+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ren_valid  in  RENAME_WIDTH  per-lane rename request (lane 0 oldest)
ren_dest  in  RENAME_WIDTH*AW  destination arch reg per lane
ren_src1, ren_src2  in  RENAME_WIDTH*AW  source arch regs per lane
ren_ready  out  1  group accepted this cycle
ren_pdest  out  RENAME_WIDTH*PW  allocated phys reg per lane
ren_old_pdest  out  RENAME_WIDTH*PW  previous mapping of dest, sent to ROB
ren_old_valid  out  RENAME_WIDTH  previous mapping existed
ren_psrc1, ren_psrc2  out  RENAME_WIDTH*PW  source phys regs
ren_src1_found, ren_src2_found  out  RENAME_WIDTH  source mapping valid
free_valid  in  FREE_WIDTH  commit returns a phys reg
free_preg  in  FREE_WIDTH*PW  phys reg to free
ckpt_save  in  1  snapshot state (branch renamed)
ckpt_restore  in  1  mispredict: roll back to snapshot
ckpt_valid  out  1  snapshot held
free_count  out  CW  number of free phys regs (registered state)

Behaviour:
- Reset (async, rst_n=0): map per INIT_MAP; free list as per INIT_MAP; ckpt_valid=0; freed-since mask=0; free_count=16-8=8 (defaults, INIT_MAP=1) or 16 (INIT_MAP=0). Combinational outputs follow the reset state.
- Accept rule: ren_ready = !ckpt_restore && (free_count >= popcount(ren_valid)). Acceptance is all-or-nothing. The group is accepted at the clock edge when ren_ready=1 and |ren_valid. The upstream holds inputs while ren_ready=0.
- Allocation: valid lanes take free regs in ascending index order, packed. The k-th valid lane gets the k-th lowest free reg. Outputs for invalid lanes are don't-care, driven 0.
- Reads are combinational from the current table. For lane k, a source matching the dest of any valid lane j<k takes the newest such j's pdest, with found=1. ren_old_pdest/ren_old_valid use the same bypass; otherwise they come from the table.
- Same dest in several lanes: the youngest lane's pdest is written to the table.
- Frees: at the edge, each free_valid sets free_list[free_preg] and sets the freed-since bit. A reg freed this cycle is not allocatable until the next cycle. Freeing an already-free reg is a protocol error: the bit stays 1 and a simulation assertion fires. Duplicate frees in the same cycle count once.
- free_count next = count - allocated + distinct newly freed. It never exceeds NUM_PHYS_REGS.
- Checkpoint save: captures the map and free list as they are after this cycle's rename and frees (post-edge state). It sets ckpt_valid=1 and clears the freed-since mask. A new save overwrites the old snapshot.
- Restore, with ckpt_valid=1:
  - next map = snapshot map.
  - next free list = snapshot free list | freed-since mask | this cycle's frees.
  - free_count is recomputed from that list.
  - ckpt_valid is cleared.
  - Save in the same cycle is ignored. Rename is blocked.
- Restore with ckpt_valid=0: ignored apart from blocking rename that cycle.
- Lane-0 bypass is not needed. Every path to the table and free list is single-cycle, with no internal pipeline.

Test Plan:
- Reset defaults, then rename lane0 r3, lane1 r5 -> pdest p8/p9, old p3/p5 with old_valid=1, free_count 8->6; next cycle src r3 reads p8.
- Intra-group: lane0 dest r2, lane1 dest r2 with src1 r2 -> lane1 psrc1=p8, old_pdest=p8; table r2=p9 afterwards.
- Exhaust: rename until free_count=1, then present 2 valid lanes -> ren_ready=0, state unchanged; 1 valid lane -> accepted, free_count=0.
- Free/alloc collision: free_count=0, free p3 while lane0 valid -> ren_ready=0 that cycle; next cycle lane0 gets p3.
- Checkpoint: save, rename r1->p8 and r4->p9, commit frees p2, restore -> r1=p1, r4=p4, p8/p9/p2 all free, free_count=9, ckpt_valid=0.
- Async reset mid-group (rst_n low between edges) -> outputs and free_count return to reset values immediately; no partial allocation survives.
